io_arbiter: RTL and testbench

Two-requester controller that shares the memory-mapped I/O buffer (input ports A/B at addresses 0/1, output ports C/D at addresses 2/3) between independent requesters, e.g. the pipeline MEM stage and a debug/loader port. It arbitrates requests, drives the buffer's ADDRESS/DATAIN/SETIO inputs, and waits out the buffer's registered read latency. It returns read data or write completion with a one-cycle ACK, and rejects illegal accesses with ERR. It sits between the requesters and the I/O buffer; it is the only driver of the buffer's control inputs.

---
 rtl/io_arb_pkg.sv | 25 ++
 rtl/io_arbiter_if.sv | 34 +++
 rtl/io_arb_pick.sv | 22 ++
 rtl/io_arbiter.sv | 146 ++++++++++++++
 tb/tb_io_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/io_arb_pkg.sv
// Shared definitions for the two-requester I/O buffer arbiter: FSM encoding,
// buffer port addresses and the access legality rule.
package io_arb_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } arb_state_t;

    localparam logic [1:0] IO_PORT_A = 2'd0;
    localparam logic [1:0] IO_PORT_B = 2'd1;
    localparam logic [1:0] IO_PORT_C = 2'd2;
    localparam logic [1:0] IO_PORT_D = 2'd3;

    // Ports A/B are inputs (read-only), ports C/D are outputs (write-only).
    function automatic logic io_access_legal(input logic we, input logic [1:0] addr);
        if (we)
            return (addr == IO_PORT_C) || (addr == IO_PORT_D);
        return (addr == IO_PORT_A) || (addr == IO_PORT_B);
    endfunction

endpackage

// File: rtl/io_arbiter_if.sv
// Bundle of requester handshakes and I/O buffer control lines around io_arbiter.
// The slave modport is the arbiter's view; master is the requesters plus buffer.
interface io_arbiter_if;
    import io_arb_pkg::*;

    logic              REQ0;
    logic              REQ1;
    logic              WE0;
    logic              WE1;
    logic [1:0]        ADDR0;
    logic [1:0]        ADDR1;
    logic [DATA_W-1:0] WDATA0;
    logic [DATA_W-1:0] WDATA1;
    logic              ACK0;
    logic              ACK1;
    logic [DATA_W-1:0] RDATA;
    logic              ERR;
    logic              BUSY;
    logic [1:0]        IO_ADDR;
    logic [DATA_W-1:0] IO_WDATA;
    logic              IO_SETIO;
    logic [DATA_W-1:0] IO_RDATA;

    modport slave (
        input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, IO_RDATA,
        output ACK0, ACK1, RDATA, ERR, BUSY, IO_ADDR, IO_WDATA, IO_SETIO
    );

    modport master (
        output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, IO_RDATA,
        input  ACK0, ACK1, RDATA, ERR, BUSY, IO_ADDR, IO_WDATA, IO_SETIO
    );

endinterface

// File: rtl/io_arb_pick.sv
// Combinational 2-way winner select. IO_ARB_ROUND_ROBIN_EN selects round-robin
// using the last winner; otherwise requester 0 has fixed priority.
module io_arb_pick
    import io_arb_pkg::*;
(
    input  logic [1:0] req,
`ifdef IO_ARB_ROUND_ROBIN_EN
    input  logic       last,
`endif
    output logic       valid,
    output logic       winner
);

    assign valid = |req;

`ifdef IO_ARB_ROUND_ROBIN_EN
    assign winner = (&req) ? ~last : req[1];
`else
    assign winner = ~req[0];
`endif

endmodule

// File: rtl/io_arbiter.sv
// Two-requester arbiter for the memory-mapped I/O buffer: IDLE -> ISSUE -> CAPTURE
// with a one-cycle ACK. Define IO_ARB_ROUND_ROBIN_EN for round-robin arbitration.
module io_arbiter
    import io_arb_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    io_arbiter_if.slave bus
);

    arb_state_t        state;
    arb_state_t        state_next;

    logic              lat_we, lat_legal, lat_winner;
    logic              we_d, legal_d, winner_d;
    logic              ack0_q, ack1_q, err_q, setio_q;
    logic              ack0_d, ack1_d, err_d, setio_d;
    logic [1:0]        addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [1:0]        req_masked;
    logic              pick_valid;
    logic              pick_winner;
    logic              sel_we;
    logic              sel_legal;
    logic [1:0]        sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef IO_ARB_ROUND_ROBIN_EN
    logic              last_q, last_d;
`endif

    // A requester whose ACK is showing this cycle is still holding REQ for the
    // finished transaction, so it must not win again until the next cycle.
    assign req_masked = {bus.REQ1 & ~ack1_q, bus.REQ0 & ~ack0_q};

    io_arb_pick u_pick (
        .req    (req_masked),
`ifdef IO_ARB_ROUND_ROBIN_EN
        .last   (last_q),
`endif
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    assign sel_we    = pick_winner ? bus.WE1    : bus.WE0;
    assign sel_addr  = pick_winner ? bus.ADDR1  : bus.ADDR0;
    assign sel_wdata = pick_winner ? bus.WDATA1 : bus.WDATA0;
    assign sel_legal = io_access_legal(sel_we, sel_addr);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        setio_d    = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        err_d      = 1'b0;
        rdata_d    = '0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = lat_we;
        legal_d    = lat_legal;
        winner_d   = lat_winner;
`ifdef IO_ARB_ROUND_ROBIN_EN
        last_d     = last_q;
`endif
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next = ST_ISSUE;
                    winner_d   = pick_winner;
                    we_d       = sel_we;
                    legal_d    = sel_legal;
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
                    setio_d    = sel_we & sel_addr[1] & sel_legal;
`ifdef IO_ARB_ROUND_ROBIN_EN
                    last_d     = pick_winner;
`endif
                end
            end
            ST_ISSUE: begin
                state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_next = ST_IDLE;
                ack0_d     = ~lat_winner;
                ack1_d     = lat_winner;
                err_d      = ~lat_legal;
                rdata_d    = (lat_legal && !lat_we) ? bus.IO_RDATA : '0;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lat_we     <= 1'b0;
            lat_legal  <= 1'b0;
            lat_winner <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            setio_q    <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
`ifdef IO_ARB_ROUND_ROBIN_EN
            last_q     <= 1'b1;
`endif
        end else begin
            lat_we     <= we_d;
            lat_legal  <= legal_d;
            lat_winner <= winner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            setio_q    <= setio_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
`ifdef IO_ARB_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

    assign bus.ACK0     = ack0_q;
    assign bus.ACK1     = ack1_q;
    assign bus.ERR      = err_q;
    assign bus.RDATA    = rdata_q;
    assign bus.IO_ADDR  = addr_q;
    assign bus.IO_WDATA = wdata_q;
    assign bus.IO_SETIO = setio_q;
    assign bus.BUSY     = (state == ST_ISSUE) || (state == ST_CAPTURE);

endmodule

// File: tb/tb_io_arbiter.sv
// Self-checking bench for io_arbiter: a behavioural I/O buffer, a vector table of
// single transactions, contention and reset-mid-write sequences, and an ACK scoreboard.
module tb_io_arbiter;
    import io_arb_pkg::*;

    localparam logic [31:0] PORT_A_VAL = 32'hDEADBEEF;
    localparam logic [31:0] PORT_B_VAL = 32'h0BADF00D;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    io_arbiter_if bus();

    io_arbiter dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    // Behavioural buffer: input ports sampled one edge before DATAOUT, outputs written on SETIO.
    logic [31:0] port_a      = PORT_A_VAL;
    logic [31:0] port_b      = PORT_B_VAL;
    logic [31:0] port_c      = 32'h0;
    logic [31:0] port_d      = 32'h0;
    logic [31:0] in_a_q      = 32'h0;
    logic [31:0] in_b_q      = 32'h0;
    logic [31:0] buf_dataout = 32'h0;

    always @(posedge CLK) begin
        in_a_q <= port_a;
        in_b_q <= port_b;
        if (bus.IO_SETIO && bus.IO_ADDR == IO_PORT_C) port_c <= bus.IO_WDATA;
        if (bus.IO_SETIO && bus.IO_ADDR == IO_PORT_D) port_d <= bus.IO_WDATA;
        case (bus.IO_ADDR)
            IO_PORT_A: buf_dataout <= in_a_q;
            IO_PORT_B: buf_dataout <= in_b_q;
            IO_PORT_C: buf_dataout <= port_c;
            default:   buf_dataout <= port_d;
        endcase
    end
    assign bus.IO_RDATA = buf_dataout;

    typedef struct {
        logic        id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        id;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_setio;
        logic [31:0] exp_c;
        logic [31:0] exp_d;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[10];
    int   checks      = 0;
    int   failures    = 0;
    int   setio_count = 0;
    logic model_last  = 1'b1;

    task automatic check_value(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Scoreboard: every ACK must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (bus.IO_SETIO === 1'b1) setio_count++;
        if (bus.ACK0 === 1'b1 || bus.ACK1 === 1'b1) begin
            if (bus.ACK0 === 1'b1 && bus.ACK1 === 1'b1)
                check_value("dual_ack", 32'd1, 32'd0);
            if (exp_q.size() == 0) begin
                check_value("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_value("ack_id", 32'(bus.ACK1), 32'(e.id));
                check_value("ack_rdata", bus.RDATA, e.rdata);
                check_value("ack_err", 32'(bus.ERR), 32'(e.err));
                model_last = e.id;
            end
        end
    end

    task automatic drive_req(input logic id, input logic on, input logic we,
                             input logic [1:0] addr, input logic [31:0] wdata);
        if (id == 1'b0) begin
            bus.REQ0 = on; bus.WE0 = we; bus.ADDR0 = addr; bus.WDATA0 = wdata;
        end else begin
            bus.REQ1 = on; bus.WE1 = we; bus.ADDR1 = addr; bus.WDATA1 = wdata;
        end
    endtask

    task automatic apply_stimulus(input vec_t v, output int lat, output int busy);
        exp_q.push_back(exp_t'{v.id, v.exp_rdata, v.exp_err});
        @(posedge CLK); #1;
        setio_count = 0;
        drive_req(v.id, 1'b1, v.we, v.addr, v.wdata);
        lat  = 0;
        busy = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge CLK);
            if (bus.BUSY === 1'b1) busy++;
            if ((v.id ? bus.ACK1 : bus.ACK0) === 1'b1) begin
                lat = c;
                break;
            end
        end
        @(posedge CLK); #1;
        drive_req(v.id, 1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    task automatic check_output(input string tag, input vec_t v, input int lat, input int busy);
        check_value({tag, "_latency"}, 32'(lat), 32'd4);
        check_value({tag, "_busy"}, 32'(busy), 32'd2);
        check_value({tag, "_setio"}, 32'(setio_count), 32'(v.exp_setio));
        check_value({tag, "_port_c"}, port_c, v.exp_c);
        check_value({tag, "_port_d"}, port_d, v.exp_d);
    endtask

    task automatic hold_requester(input logic id, input int n, input string tag);
        int cnt = 0;
        for (int c = 0; c < 100 && cnt < n; c++) begin
            @(negedge CLK);
            if ((id ? bus.ACK1 : bus.ACK0) === 1'b1) cnt++;
        end
        check_value($sformatf("%s_acks%0d", tag, id), 32'(cnt), 32'(n));
        @(posedge CLK); #1;
        drive_req(id, 1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    // Both requesters raise together and keep re-requesting; the policy picks the
    // first grant, then ACK masking hands every following grant to the other side.
    task automatic run_contention(input int n_each, input string tag);
        logic first;
`ifdef IO_ARB_ROUND_ROBIN_EN
        first = ~model_last;
`else
        first = 1'b0;
`endif
        for (int k = 0; k < 2 * n_each; k++) begin
            logic id;
            id = first ^ k[0];
            exp_q.push_back(exp_t'{id, id ? PORT_B_VAL : PORT_A_VAL, 1'b0});
        end
        @(posedge CLK); #1;
        drive_req(1'b0, 1'b1, 1'b0, IO_PORT_A, 32'h0);
        drive_req(1'b1, 1'b1, 1'b0, IO_PORT_B, 32'h0);
        fork
            hold_requester(1'b0, n_each, tag);
            hold_requester(1'b1, n_each, tag);
        join
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat, busy, acks;
        logic [31:0] port_d_before;
        vec_t        post;

        vecs[0] = '{1'b0, 1'b0, IO_PORT_A, 32'h0,        PORT_A_VAL, 1'b0, 0, 32'h0,        32'h0};
        vecs[1] = '{1'b1, 1'b0, IO_PORT_B, 32'h0,        PORT_B_VAL, 1'b0, 0, 32'h0,        32'h0};
        vecs[2] = '{1'b1, 1'b1, IO_PORT_C, 32'h12345678, 32'h0,      1'b0, 1, 32'h12345678, 32'h0};
        vecs[3] = '{1'b0, 1'b1, IO_PORT_D, 32'hCAFEF00D, 32'h0,      1'b0, 1, 32'h12345678, 32'hCAFEF00D};
        vecs[4] = '{1'b0, 1'b1, IO_PORT_B, 32'hFFFF0000, 32'h0,      1'b1, 0, 32'h12345678, 32'hCAFEF00D};
        vecs[5] = '{1'b1, 1'b0, IO_PORT_D, 32'h0,        32'h0,      1'b1, 0, 32'h12345678, 32'hCAFEF00D};
        vecs[6] = '{1'b1, 1'b0, IO_PORT_C, 32'h0,        32'h0,      1'b1, 0, 32'h12345678, 32'hCAFEF00D};
        vecs[7] = '{1'b0, 1'b1, IO_PORT_A, 32'h55555555, 32'h0,      1'b1, 0, 32'h12345678, 32'hCAFEF00D};
        vecs[8] = '{1'b1, 1'b1, IO_PORT_D, 32'h00C0FFEE, 32'h0,      1'b0, 1, 32'h12345678, 32'h00C0FFEE};
        vecs[9] = '{1'b0, 1'b0, IO_PORT_A, 32'h0,        PORT_A_VAL, 1'b0, 0, 32'h12345678, 32'h00C0FFEE};

        drive_req(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        drive_req(1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_value("rst_ack0", 32'(bus.ACK0), 32'd0);
        check_value("rst_ack1", 32'(bus.ACK1), 32'd0);
        check_value("rst_err", 32'(bus.ERR), 32'd0);
        check_value("rst_rdata", bus.RDATA, 32'd0);
        check_value("rst_busy", 32'(bus.BUSY), 32'd0);
        check_value("rst_setio", 32'(bus.IO_SETIO), 32'd0);
        check_value("rst_io_addr", 32'(bus.IO_ADDR), 32'd0);
        check_value("rst_io_wdata", bus.IO_WDATA, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b1;
        model_last = 1'b1;

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i], lat, busy);
            check_output($sformatf("vec%0d", i), vecs[i], lat, busy);
        end

        run_contention(2, "cont_a");
        run_contention(2, "cont_b");

        // Reset lands in the ISSUE cycle of a write to port D.
        port_d_before = port_d;
        @(posedge CLK); #1;
        drive_req(1'b0, 1'b1, 1'b1, IO_PORT_D, 32'h11111111);
        @(posedge CLK);
        @(negedge CLK);
        check_value("midrst_issue_setio", 32'(bus.IO_SETIO), 32'd1);
        check_value("midrst_issue_busy", 32'(bus.BUSY), 32'd1);
        #2;
        RST = 1'b0;
        #1;
        check_value("midrst_setio", 32'(bus.IO_SETIO), 32'd0);
        check_value("midrst_busy", 32'(bus.BUSY), 32'd0);
        drive_req(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            if (bus.ACK0 === 1'b1 || bus.ACK1 === 1'b1) acks++;
        end
        check_value("midrst_no_ack", 32'(acks), 32'd0);
        check_value("midrst_port_d", port_d, port_d_before);
        @(posedge CLK); #1;
        RST = 1'b1;
        model_last = 1'b1;

        post = '{1'b0, 1'b1, IO_PORT_D, 32'hA5A5A5A5, 32'h0, 1'b0, 1, 32'h12345678, 32'hA5A5A5A5};
        apply_stimulus(post, lat, busy);
        check_output("post_rst", post, lat, busy);

        run_contention(1, "cont_c");

        repeat (3) @(posedge CLK);
        check_value("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
